bind_command_queue: RTL and testbench

Command buffer and dispatcher directly upstream of the bind kernel mapper. It accepts bind requests from the host/sequencer, holds them in a small FIFO, and issues them to the mapper one at a time. Each request is a vector length and three hypervector base addresses (hva, hvb, hvc). The mapper's single-cycle `valid` / level `done` protocol is converted into a standard `valid`/`ready` command stream. Zero-length commands are filtered out before they reach the mapper.

---
 rtl/bind_command_queue.sv | 124 ++++++++++++
 tb/tb_bind_command_queue.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bind_command_queue.sv
// Command FIFO and single-outstanding dispatcher in front of the bind kernel mapper.
// Optional BIND_CMD_STATS_EN adds saturating ops_completed / busy_cycles counters.
module bind_command_queue #(
  parameter int HV_ADDRESS_WIDTH = 20,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                cmd_valid,
  output logic                                cmd_ready,
  input  logic [HV_ADDRESS_WIDTH-1:0]         cmd_length,
  input  logic [HV_ADDRESS_WIDTH-1:0]         cmd_hva,
  input  logic [HV_ADDRESS_WIDTH-1:0]         cmd_hvb,
  input  logic [HV_ADDRESS_WIDTH-1:0]         cmd_hvc,
  output logic                                map_valid,
  output logic [HV_ADDRESS_WIDTH-1:0]         map_vec_length,
  output logic [HV_ADDRESS_WIDTH-1:0]         map_hva,
  output logic [HV_ADDRESS_WIDTH-1:0]         map_hvb,
  output logic [HV_ADDRESS_WIDTH-1:0]         map_hvc,
  input  logic                                map_done,
  output logic [$clog2(FIFO_DEPTH):0]         fifo_count,
  output logic                                busy,
  output logic                                cmd_dropped
`ifdef BIND_CMD_STATS_EN
  ,
  output logic [31:0]                         ops_completed,
  output logic [31:0]                         busy_cycles
`endif
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = 4 * HV_ADDRESS_WIDTH;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] ACK   = 2'd2;
  localparam logic [1:0] RUN   = 2'd3;

  logic [ENTRY_W-1:0]          mem [FIFO_DEPTH];
  logic [PTR_W-1:0]            wr_ptr;
  logic [PTR_W-1:0]            rd_ptr;
  logic [1:0]                  state;
  logic                        push;
  logic                        pop;
  logic [HV_ADDRESS_WIDTH-1:0] head_len;
  logic [HV_ADDRESS_WIDTH-1:0] head_hva;
  logic [HV_ADDRESS_WIDTH-1:0] head_hvb;
  logic [HV_ADDRESS_WIDTH-1:0] head_hvc;

  // Ready comes only from the registered count, never from cmd_valid.
  assign cmd_ready = (fifo_count != CNT_W'(FIFO_DEPTH));
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state == IDLE) && (fifo_count != '0) && map_done;
  assign busy      = (state != IDLE) || (fifo_count != '0);
  assign {head_len, head_hva, head_hvb, head_hvc} = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd_length, cmd_hva, cmd_hvb, cmd_hvc};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fifo_count     <= '0;
      state          <= IDLE;
      map_valid      <= 1'b0;
      cmd_dropped    <= 1'b0;
      map_vec_length <= '0;
      map_hva        <= '0;
      map_hvb        <= '0;
      map_hvc        <= '0;
    end else begin
      map_valid   <= 1'b0;
      cmd_dropped <= 1'b0;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
      case (state)
        IDLE: begin
          if (pop) begin
            if (head_len == '0) begin
              cmd_dropped <= 1'b1;
            end else begin
              map_vec_length <= head_len;
              map_hva        <= head_hva;
              map_hvb        <= head_hvb;
              map_hvc        <= head_hvc;
              map_valid      <= 1'b1;
              state          <= ISSUE;
            end
          end
        end
        ISSUE:   state <= ACK;
        // The mapper signals acceptance by dropping its done level.
        ACK:     if (!map_done) state <= RUN;
        RUN:     if (map_done) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BIND_CMD_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ops_completed <= '0;
      busy_cycles   <= '0;
    end else begin
      if ((state == RUN) && map_done) ops_completed <= sat_inc(ops_completed);
      if (busy) busy_cycles <= sat_inc(busy_cycles);
    end
  end
`endif

endmodule

// File: tb/tb_bind_command_queue.sv
// Directed bench for bind_command_queue with a behavioural mapper model.
module tb_bind_command_queue;
  localparam int W = 20;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [W-1:0] cmd_length, cmd_hva, cmd_hvb, cmd_hvc;
  logic         map_valid;
  logic [W-1:0] map_vec_length, map_hva, map_hvb, map_hvc;
  logic         map_done;
  logic [2:0]   fifo_count;
  logic         busy;
  logic         cmd_dropped;
`ifdef BIND_CMD_STATS_EN
  logic [31:0]  ops_completed, busy_cycles;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bind_command_queue #(.HV_ADDRESS_WIDTH(W), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_length(cmd_length), .cmd_hva(cmd_hva), .cmd_hvb(cmd_hvb), .cmd_hvc(cmd_hvc),
    .map_valid(map_valid), .map_vec_length(map_vec_length),
    .map_hva(map_hva), .map_hvb(map_hvb), .map_hvc(map_hvc),
    .map_done(map_done), .fifo_count(fifo_count), .busy(busy),
    .cmd_dropped(cmd_dropped)
`ifdef BIND_CMD_STATS_EN
    , .ops_completed(ops_completed), .busy_cycles(busy_cycles)
`endif
  );

  // Mapper model: drops done ack_delay cycles after sampling map_valid, holds it low run_cycles.
  logic done_r;
  logic hold;
  int   phase, mcnt;
  int   run_cycles;
  int   ack_delay;
  assign map_done = done_r & ~hold;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_r <= 1'b1;
      phase  <= 0;
      mcnt   <= 0;
    end else begin
      case (phase)
        0: if (map_valid) begin
             if (ack_delay == 0) begin done_r <= 1'b0; phase <= 2; mcnt <= run_cycles; end
             else begin phase <= 1; mcnt <= ack_delay; end
           end
        1: if (mcnt <= 1) begin done_r <= 1'b0; phase <= 2; mcnt <= run_cycles; end
           else mcnt <= mcnt - 1;
        2: if (mcnt <= 1) begin done_r <= 1'b1; phase <= 0; end
           else mcnt <= mcnt - 1;
        default: phase <= 0;
      endcase
    end
  end

  logic [4*W-1:0] iss_q[$];
  int   drop_cnt = 0;
  int   vld_wide = 0;
  logic vld_prev = 1'b0;

  always @(posedge clk) begin
    if (map_valid) iss_q.push_back({map_vec_length, map_hva, map_hvb, map_hvc});
    if (map_valid && vld_prev) vld_wide <= vld_wide + 1;
    vld_prev <= map_valid;
    if (cmd_dropped) drop_cnt <= drop_cnt + 1;
  end

  function automatic logic [4*W-1:0] pack(input int len, input int a, input int b, input int c);
    return {W'(len), W'(a), W'(b), W'(c)};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int len, input int a, input int b, input int c);
    logic acc;
    acc = 1'b0;
    cmd_length = W'(len); cmd_hva = W'(a); cmd_hvb = W'(b); cmd_hvc = W'(c);
    cmd_valid = 1'b1;
    for (int i = 0; i < 500 && !acc; i++) begin
      if (cmd_ready) acc = 1'b1;
      step();
    end
    cmd_valid = 1'b0;
    chk("push_accept", acc, 1'b1);
  endtask

  task automatic wait_idle(input int limit);
    for (int i = 0; i < limit && busy; i++) step();
    chk("idle_timeout", busy, 1'b0);
    step();
  endtask

  task automatic wait_valid(input int limit);
    for (int i = 0; i < limit && !map_valid; i++) step();
    chk("valid_timeout", map_valid, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int base, dbase;
    reset_n = 1'b0; cmd_valid = 1'b0; hold = 1'b0;
    cmd_length = '0; cmd_hva = '0; cmd_hvb = '0; cmd_hvc = '0;
    run_cycles = 10; ack_delay = 0;
    repeat (3) step();

    // Reset state
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_map_valid", map_valid, 1'b0);
    chk("rst_map_fields", {map_vec_length, map_hva, map_hvb, map_hvc}, '0);
    chk("rst_fifo_count", fifo_count, 3'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_dropped", cmd_dropped, 1'b0);
    reset_n = 1'b1;
    step();

    // Single command, 10-cycle mapper run
    push(8, 'h100, 'h200, 'h300);
    chk("t1_count_after_push", fifo_count, 3'd1);
    chk("t1_valid_latency_low", map_valid, 1'b0);
    step();
    chk("t1_map_valid", map_valid, 1'b1);
    chk("t1_fields", {map_vec_length, map_hva, map_hvb, map_hvc}, pack(8, 'h100, 'h200, 'h300));
    chk("t1_count_after_pop", fifo_count, 3'd0);
    step();
    chk("t1_valid_width", map_valid, 1'b0);
    wait_idle(60);
    chk("t1_done_high", map_done, 1'b1);
    chk("t1_issue_count", iss_q.size(), 1);
    chk("t1_fields_stable", map_hva, W'('h100));
`ifdef BIND_CMD_STATS_EN
    chk("t1_ops_completed", ops_completed, 32'd1);
    chk("t1_busy_cycles", busy_cycles, 32'd13);
`endif

    // Six commands with the mapper held busy
    run_cycles = 3;
    base = iss_q.size();
    hold = 1'b1;
    for (int i = 0; i < 4; i++) push(i + 1, 'h1000 + i, 'h2000 + i, 'h3000 + i);
    chk("t2_full_count", fifo_count, 3'd4);
    chk("t2_ready_low", cmd_ready, 1'b0);
    cmd_length = W'(5); cmd_hva = W'('h1004); cmd_hvb = W'('h2004); cmd_hvc = W'('h3004);
    cmd_valid = 1'b1;
    repeat (3) step();
    chk("t2_held_count", fifo_count, 3'd4);
    chk("t2_held_ready", cmd_ready, 1'b0);
    hold = 1'b0;
    for (int i = 4; i < 6; i++) push(i + 1, 'h1000 + i, 'h2000 + i, 'h3000 + i);
    wait_idle(400);
    chk("t2_issue_count", iss_q.size() - base, 6);
    for (int i = 0; i < 6; i++)
      chk("t2_issue_order", iss_q[base + i], pack(i + 1, 'h1000 + i, 'h2000 + i, 'h3000 + i));

    // Zero-length filtering
    base = iss_q.size(); dbase = drop_cnt;
    push(0, 'h11, 'h12, 'h13);
    push(5, 'h500, 'h600, 'h700);
    push(0, 'h21, 'h22, 'h23);
    wait_idle(200);
    chk("t3_drop_count", drop_cnt - dbase, 2);
    chk("t3_issue_count", iss_q.size() - base, 1);
    chk("t3_issue_fields", iss_q[base], pack(5, 'h500, 'h600, 'h700));

    // Simultaneous push/pop at count 2 across pointer wraps
    base = iss_q.size(); dbase = drop_cnt;
    hold = 1'b1;
    push(0, 0, 0, 0);
    push(0, 0, 0, 0);
    chk("t4_preload", fifo_count, 3'd2);
    cmd_length = '0; cmd_hva = '0; cmd_hvb = '0; cmd_hvc = '0;
    cmd_valid = 1'b1;
    hold = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i == 11) begin
        cmd_length = W'(7); cmd_hva = W'('h7A1); cmd_hvb = W'('h7B2); cmd_hvc = W'('h7C3);
      end
      step();
      chk("t4_count_steady", fifo_count, 3'd2);
    end
    cmd_valid = 1'b0;
    wait_idle(200);
    chk("t4_drop_count", drop_cnt - dbase, 13);
    chk("t4_issue_count", iss_q.size() - base, 1);
    chk("t4_issue_fields", iss_q[base], pack(7, 'h7A1, 'h7B2, 'h7C3));

    // Mapper acknowledges 3 cycles late
    ack_delay = 3; run_cycles = 4;
    base = iss_q.size();
    push(9, 'h910, 'h920, 'h930);
    wait_valid(20);
    step();
    for (int i = 0; i < 3; i++) begin
      chk("t5_no_revalid", map_valid, 1'b0);
      chk("t5_busy_in_ack", busy, 1'b1);
      step();
    end
    chk("t5_ack_seen", map_done, 1'b0);
    wait_idle(200);
    chk("t5_issue_count", iss_q.size() - base, 1);
    chk("t5_issue_fields", iss_q[base], pack(9, 'h910, 'h920, 'h930));
    ack_delay = 0;

    // Reset during RUN with three commands queued
    run_cycles = 30;
    push(4, 'hA1, 'hA2, 'hA3);
    wait_valid(20);
    repeat (3) step();
    push(11, 'hB1, 'hB2, 'hB3);
    push(12, 'hC1, 'hC2, 'hC3);
    push(13, 'hD1, 'hD2, 'hD3);
    chk("t6_queued", fifo_count, 3'd3);
    chk("t6_busy", busy, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_rst_cmd_ready", cmd_ready, 1'b1);
    chk("t6_rst_map_valid", map_valid, 1'b0);
    chk("t6_rst_map_fields", {map_vec_length, map_hva, map_hvb, map_hvc}, '0);
    chk("t6_rst_fifo_count", fifo_count, 3'd0);
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_dropped", cmd_dropped, 1'b0);
`ifdef BIND_CMD_STATS_EN
    chk("t6_rst_ops", ops_completed, 32'd0);
    chk("t6_rst_busy_cycles", busy_cycles, 32'd0);
`endif
    step();
    reset_n = 1'b1;
    run_cycles = 3;
    step();
    chk("t6_post_count", fifo_count, 3'd0);
    chk("t6_post_ready", cmd_ready, 1'b1);
    chk("t6_post_busy", busy, 1'b0);
    base = iss_q.size();
    push(6, 'hE1, 'hE2, 'hE3);
    wait_idle(100);
    chk("t6_flush_issue_count", iss_q.size() - base, 1);
    chk("t6_flush_fields", iss_q[base], pack(6, 'hE1, 'hE2, 'hE3));

    chk("valid_pulse_width", vld_wide, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
